// File: rtl/mapping_post_quant.sv
//==============================================================================
// Module      : mapping_post_quant
// Description : Bias add, rounding shift and ReLU/saturate of PE results,
//               buffered two vectors deep and streamed three bytes per beat.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mapping_post_quant #(
    parameter int                   NUM_CH    = 12,
    parameter int                   OUT_SHIFT = 7,
    parameter logic [NUM_CH*16-1:0] BIAS      = '0
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [NUM_CH*24-1:0] i_result,
    input  logic                 i_valid,
    output logic [23:0]          o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_last,
    output logic                 o_overflow
);

    localparam int                NUM_BEATS   = NUM_CH / 3;
    localparam int                K_W         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [K_W-1:0]    c_LAST_BEAT = K_W'(NUM_BEATS - 1);
    localparam logic signed [26:0] c_RND      = 27'sd1 <<< (OUT_SHIFT - 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_STREAM = 1'b1;

    logic                  r_va;
    logic                  r_vb;
    logic [NUM_CH*8-1:0]   w_q;
    logic [NUM_CH*8-1:0]   r_q_b;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic signed [25:0] w_sum;
            logic signed [25:0] r_sum_a;
            logic signed [26:0] w_rnd;
            logic signed [26:0] w_shr;

            assign w_sum = {{2{i_result[24*c+23]}}, i_result[24*c +: 24]}
                         + {{10{BIAS[16*c+15]}}, BIAS[16*c +: 16]};

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_sum_a <= '0;
                end else if (i_valid) begin
                    r_sum_a <= w_sum;
                end
            end

            // One guard bit keeps the rounding add from wrapping near full scale
            assign w_rnd = {r_sum_a[25], r_sum_a} + c_RND;
            assign w_shr = w_rnd >>> OUT_SHIFT;
            assign w_q[8*c +: 8] = (w_shr < 0)          ? 8'd0  :
                                   (w_shr > 27'sd255)   ? 8'hFF : w_shr[7:0];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_va  <= 1'b0;
            r_vb  <= 1'b0;
            r_q_b <= '0;
        end else begin
            r_va <= i_valid;
            r_vb <= r_va;
            if (r_va) begin
                r_q_b <= w_q;
            end
        end
    end

    logic [NUM_CH*8-1:0] r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic [K_W-1:0]      r_k;
    logic                r_overflow;
    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_hs;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic [1:0]          w_count_nxt;
    logic [NUM_CH*8-1:0] w_head;

    assign w_hs        = o_valid && i_ready;
    assign w_pop       = w_hs && (r_k == c_LAST_BEAT);
    assign w_full      = (r_count == 2'd2);
    // A full buffer still accepts a write when the head leaves in the same cycle
    assign w_push      = r_vb && (!w_full || w_pop);
    assign w_drop      = r_vb && w_full && !w_pop;
    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_k        <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_q_b;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= w_count_nxt;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_hs) begin
                r_k <= w_pop ? '0 : r_k + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_count_nxt != 2'd0) begin
                    w_state_nxt = c_STREAM;
                end
            end
            c_STREAM: begin
                if (w_pop && (w_count_nxt == 2'd0)) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        o_valid = (r_state == c_STREAM);
        o_last  = o_valid && (r_k == c_LAST_BEAT);
        o_data  = 24'd0;
        if (o_valid) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                if (r_k == K_W'(b)) begin
                    o_data = w_head[24*b +: 24];
                end
            end
        end
    end

    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_mapping_post_quant.sv
//==============================================================================
// Module      : tb_mapping_post_quant
// Description : Scoreboard bench for mapping_post_quant.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mapping_post_quant;

    localparam int NUM_CH    = 12;
    localparam int OUT_SHIFT = 7;
    localparam int NB        = NUM_CH / 3;
    localparam logic [NUM_CH*16-1:0] BIAS = {{((NUM_CH-2)*16){1'b0}}, 16'h0040, 16'hFF80};

    logic                 clk;
    logic                 i_rstn;
    logic [NUM_CH*24-1:0] i_result;
    logic                 i_valid;
    logic [23:0]          o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;
    logic                 o_overflow;

    mapping_post_quant #(
        .NUM_CH    (NUM_CH),
        .OUT_SHIFT (OUT_SHIFT),
        .BIAS      (BIAS)
    ) u_dut (
        .i_clk      (clk),
        .i_rstn     (i_rstn),
        .i_result   (i_result),
        .i_valid    (i_valid),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [24:0] sb [$];
    int n_cmp   = 0;
    int n_err   = 0;
    int n_hs    = 0;
    int t_hs    = 0;
    int t_last  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int res, input int bias);
        int s;
        int r;
        s = res + bias;
        r = (s + (1 << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
        if (r < 0)   return 8'd0;
        if (r > 255) return 8'd255;
        return r[7:0];
    endfunction

    task automatic send(input logic [NUM_CH*24-1:0] res, input bit exp_push);
        logic [23:0] word;
        int          ch;
        @(posedge clk); #1;
        i_result = res;
        i_valid  = 1'b1;
        t_last   = cyc;
        if (exp_push) begin
            for (int k = 0; k < NB; k++) begin
                for (int j = 0; j < 3; j++) begin
                    ch = 3*k + j;
                    word[8*j +: 8] = ref_byte($signed(res[24*ch +: 24]), $signed(BIAS[16*ch +: 16]));
                end
                sb.push_back({(k == NB-1), word});
            end
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        check("drain_left", sb.size(), 0);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_valid) break;
        end
    endtask

    function automatic logic [NUM_CH*24-1:0] rand_vec();
        logic [NUM_CH*24-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[24*c +: 24] = 24'($urandom);
        return v;
    endfunction

    // Every presented beat is compared to the scoreboard head; accepted beats retire it
    always @(negedge clk) begin
        if (i_rstn && o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", o_valid, 0);
            end else begin
                check("o_data", o_data, sb[0][23:0]);
                check("o_last", o_last, sb[0][24]);
                if (i_ready) begin
                    void'(sb.pop_front());
                    n_hs++;
                    t_hs = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH*24-1:0] v;
        int t0;
        int hs0;

        i_rstn   = 1'b1;
        i_valid  = 1'b0;
        i_ready  = 1'b1;
        i_result = '0;
        #1 i_rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_last", o_last, 0);
        check("rst_o_overflow", o_overflow, 0);
        @(posedge clk); #1 i_rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Basic ramp and first-beat latency
        for (int c = 0; c < NUM_CH; c++) v[24*c +: 24] = 24'(128*c);
        send(v, 1'b1);
        t0 = t_last;
        wait_valid();
        check("latency", cyc - t0, 3);
        drain();

        // Rounding and saturation corners
        v = rand_vec();
        v[24*2 +: 24] = 24'd191;
        v[24*3 +: 24] = 24'd192;
        v[24*4 +: 24] = -24'sd1000;
        v[24*5 +: 24] = 24'h7FFFFF;
        v[24*6 +: 24] = 24'd32767;
        v[24*7 +: 24] = 24'd0;
        send(v, 1'b1);
        drain();

        // Bias on channels 0 and 1
        v = rand_vec();
        v[24*0 +: 24] = 24'd384;
        v[24*1 +: 24] = 24'd0;
        send(v, 1'b1);
        drain();

        // Sustained throughput, one vector every NB cycles
        for (int n = 0; n < 5; n++) begin
            send(rand_vec(), 1'b1);
            repeat (NB - 2) @(posedge clk);
        end
        drain();

        // Backpressure on beat 0
        @(posedge clk); #1 i_ready = 1'b0;
        send(rand_vec(), 1'b1);
        wait_valid();
        repeat (10) @(negedge clk);
        check("bp_held", sb.size(), NB);
        @(posedge clk); #1 i_ready = 1'b1;
        t0  = cyc;
        hs0 = n_hs;
        drain();
        check("bp_beats", n_hs - hs0, NB);
        check("bp_consecutive", t_hs - t0, NB - 1);

        // Overflow: two vectors buffered, third dropped
        @(posedge clk); #1 i_ready = 1'b0;
        check("ovf_pre", o_overflow, 0);
        send(rand_vec(), 1'b1);
        repeat (2) @(posedge clk);
        send(rand_vec(), 1'b1);
        repeat (2) @(posedge clk);
        send(rand_vec(), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("ovf_before_drop", o_overflow, 0);
        @(negedge clk);
        check("ovf_after_drop", o_overflow, 1);
        hs0 = n_hs;
        @(posedge clk); #1 i_ready = 1'b1;
        drain();
        repeat (4) @(negedge clk);
        check("ovf_beats", n_hs - hs0, 2*NB);
        check("ovf_sticky", o_overflow, 1);
        check("ovf_idle", o_valid, 0);

        // Reset in the middle of a vector
        send(rand_vec(), 1'b1);
        wait_valid();
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rstn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_o_valid", o_valid, 0);
        check("mid_rst_o_overflow", o_overflow, 0);
        @(posedge clk); #1 i_rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_o_valid", o_valid, 0);
        check("post_rst_o_last", o_last, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
